// File: rtl/dpcm_decoder_if.sv
// Handshake bundle between the DPCM decoder and its neighbours: code input
// channel, sample output channel and the clip counter status.
interface dpcm_decoder_if #(
   parameter int CODE_W   = 4,
   parameter int SAMPLE_W = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [CODE_W-1:0]   code;
   logic                out_valid;
   logic                out_ready;
   logic [SAMPLE_W-1:0] sample;
   logic [7:0]          sat_count;

   // Decoder side
   modport slave (
      input  in_valid, code, out_ready,
      output in_ready, out_valid, sample, sat_count
   );

   // Producer / consumer side
   modport master (
      output in_valid, code, out_ready,
      input  in_ready, out_valid, sample, sat_count
   );
endinterface

// File: rtl/dpcm_decoder.sv
// DPCM decoder: accumulates signed difference codes onto a saturating
// predictor and presents reconstructed samples through a 2-entry buffer.
module dpcm_decoder #(
   parameter int CODE_W   = 4,
   parameter int SAMPLE_W = 8,
   parameter int INIT     = 0
) (
   input logic            clock,
   input logic            reset,
   dpcm_decoder_if.slave  bus
);

   localparam int SUM_W = SAMPLE_W + 2;
   localparam logic [SAMPLE_W-1:0]     INIT_V = SAMPLE_W'(INIT);
   localparam logic signed [SUM_W-1:0] MAX_S  = {2'b00, {SAMPLE_W{1'b1}}};

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } state_t;

   state_t              state_q, state_d;
   logic [SAMPLE_W-1:0] pred_q, pred_d;
   logic [SAMPLE_W-1:0] head_q, head_d;
   logic [SAMPLE_W-1:0] tail_q, tail_d;
   logic [7:0]          sat_q, sat_d;

   logic                    accept;
   logic                    pop;
   logic signed [SUM_W-1:0] sum;
   logic [SAMPLE_W-1:0]     result;
   logic                    clipped;

   // Reconstruct the candidate sample and clip it into the legal range
   always_comb begin
      sum = $signed({2'b00, pred_q})
          + $signed({{(SUM_W-CODE_W){bus.code[CODE_W-1]}}, bus.code});
      result  = sum[SAMPLE_W-1:0];
      clipped = 1'b0;
      if (sum < 0) begin
         result  = '0;
         clipped = 1'b1;
      end else if (sum > MAX_S) begin
         result  = '1;
         clipped = 1'b1;
      end
   end

   // State register plus predictor, buffer entries and clip counter
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= EMPTY;
         pred_q  <= INIT_V;
         head_q  <= '0;
         tail_q  <= '0;
         sat_q   <= '0;
      end else begin
         state_q <= state_d;
         pred_q  <= pred_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         sat_q   <= sat_d;
      end
   end

   // Next-state logic; accept is gated by registered state only, so a pop
   // while FULL never opens the input on the same edge
   always_comb begin
      accept  = bus.in_valid && (state_q != FULL);
      pop     = bus.out_ready && (state_q != EMPTY);
      state_d = state_q;
      pred_d  = pred_q;
      head_d  = head_q;
      tail_d  = tail_q;
      sat_d   = sat_q;

      if (accept) begin
         pred_d = result;
         if (clipped && (sat_q != 8'hFF)) begin
            sat_d = sat_q + 8'd1;
         end
      end

      case (state_q)
         EMPTY: begin
            if (accept) begin
               head_d  = result;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && pop) begin
               head_d = result;
            end else if (accept) begin
               tail_d  = result;
               state_d = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Outputs derived from registered state only
   always_comb begin
      bus.in_ready  = (state_q != FULL);
      bus.out_valid = (state_q != EMPTY);
      bus.sample    = head_q;
      bus.sat_count = sat_q;
   end

endmodule

// File: doc/dpcm_decoder.md
# dpcm_decoder

Downstream stage of the `dpcm` encoder: consumes its 4-bit two's-complement difference codes over a valid/ready handshake, reconstructs samples by accumulating each difference onto a saturating predictor, and presents them through a 2-entry output buffer with its own valid/ready handshake. It sits between the encoder's `out` and any sample sink (LED display logic, UART, DAC). A counter records how many reconstructed samples were clipped.

## Interface
- `CODE_W`, 4: width of incoming difference code, two's complement.
- `SAMPLE_W`, 8: width of reconstructed unsigned sample.
- `INIT`, 0: predictor value after reset; must be in [0, 2^SAMPLE_W-1].

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `in_valid`  in  1  upstream has a code on `code`.
- `in_ready`  out  1  decoder can accept a code this cycle.
- `code`  in  CODE_W  signed difference, -8..+7 at default width.
- `out_valid`  out  1  `sample` holds a valid reconstructed sample.
- `out_ready`  in  1  downstream accepts `sample` this cycle.
- `sample`  out  SAMPLE_W  reconstructed sample, head of output buffer.
- `sat_count`  out  8  number of clipped samples, saturates at 255.

## Operation
- Accept: code transfers on an edge where `in_valid && in_ready`. Pop: sample transfers on an edge where `out_valid && out_ready`.
- Decode on accept: `next = pred + sext(code)`, computed at SAMPLE_W+2 bits signed. If `next < 0`, result is 0; if `next > 2^SAMPLE_W-1`, result is 2^SAMPLE_W-1; otherwise result is `next`. On clipping, `sat_count` increments unless already 255.
- `pred` is updated to the clipped result, so the predictor never leaves the legal range. It is pushed into the output buffer on the same edge.
- Output buffer is a 2-entry FIFO with states EMPTY, ONE, FULL:
  - EMPTY: accept leads to ONE.
  - ONE: accept with no pop leads to FULL; pop with no accept leads to EMPTY; accept and pop together stay in ONE, with the new sample becoming head.
  - FULL: pop leads to ONE; no accept is possible.
- `in_ready = (state != FULL)`, driven from registered state only. There is no combinational path from `out_ready` to `in_ready`. In FULL, a simultaneous pop does not allow an accept on the same edge.
- `out_valid = (state != EMPTY)`. `sample` is the head entry and stays stable while `out_valid && !out_ready`.
- Code values are not rejected; every accepted code produces exactly one sample, in order.

## Timing
- Reset values: `pred = INIT`, state EMPTY, `in_ready = 1`, `out_valid = 0`, `sample = 0`, `sat_count = 0`.
- Reset mid-operation discards buffered samples and the predictor. Any handshake coinciding with the reset edge is ignored.
- Latency: a code accepted at edge N makes its sample visible on `sample` with `out_valid = 1` in the cycle after edge N, when the buffer was EMPTY or ONE-with-pop.
- Throughput: one code per cycle while `out_ready` is held high.
- With `out_ready` low, at most 2 codes are accepted, then `in_ready` drops the cycle after the second accept.
- `in_ready` rises the cycle after the first pop from FULL.

## Test plan
- Reset check: assert `reset` for 2 cycles -> `in_ready = 1`, `out_valid = 0`, `sample = 0`, `sat_count = 0`.
- Basic decode with INIT=0 and `out_ready = 1`: codes +3, +3, -2, 0 -> samples 3, 6, 4, 4, each one cycle after accept; `sat_count = 0`.
- Clipping:
  - Drive 36 codes of +7 -> 35 samples rise 7..245 unclipped, then 36th sample is 252; continue +7 -> 255, with `sat_count` incremented once.
  - Then one more +7 -> 255, `sat_count = 2`.
  - Then code -8 (binary 1000) -> 247.
- Low clip: from 2, code -8 -> 0 and `sat_count` +1. From 0, code -1 -> 0 and `sat_count` +1.
- Backpressure:
  - `out_ready = 0`, `in_valid` held high with codes +1, +1, +1 -> only 2 accepted; `in_ready` low after second; `sample` holds 1.
  - Raise `out_ready` for one cycle -> 1 popped, `in_ready` high next cycle, third code accepted; drain yields 2, 3.
  - Simultaneous accept and pop in ONE keeps order.
- Reset mid-stream: buffer FULL holding 5, 6; assert `reset` together with `in_valid` -> buffer empty, predictor back to INIT; next code +2 -> sample 2.
